// File: rtl/uart_receiver_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_receiver_if
// Brief    : Serial line plus received-word outputs of the UART receiver.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_receiver_if #(
    parameter int SIZE = 8
);
    logic            rx;
    logic            rx_done;
    logic [SIZE-1:0] data_out;

    // master drives the line and consumes words; slave is the receiver
    modport master (output rx, input rx_done, input data_out);
    modport slave  (input rx, output rx_done, output data_out);
endinterface
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_receiver
// Brief    : 8N1-style UART receiver, SIZE data bits LSB first, mid-bit sampling.
// Revision : 1.0 - initial release
// ============================================================================
module uart_receiver #(
    parameter int SIZE         = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  wire logic      clk,
    input  wire logic      rst,
    uart_receiver_if.slave bus
);

    localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
    localparam int c_idx_w = $clog2(SIZE);
    localparam int c_half  = CLKS_PER_BIT / 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_sync_meta;
    logic                 r_rx_s;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_idx_w-1:0]   r_idx;
    logic [SIZE-1:0]      r_shift;
    logic [SIZE-1:0]      r_data;
    logic                 r_rx_done;

    logic                 w_cnt_clr;
    logic                 w_idx_clr;
    logic                 w_shift_en;
    logic                 w_load;
    logic                 w_mid_start;
    logic                 w_bit_end;
    logic                 w_last_bit;

    // Two-flop synchronizer; resets to the idle line level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_meta <= 1'b1;
            r_rx_s      <= 1'b1;
        end else begin
            r_sync_meta <= bus.rx;
            r_rx_s      <= r_sync_meta;
        end
    end

    assign w_mid_start = (r_cnt == c_cnt_w'(c_half - 1));
    assign w_bit_end   = (r_cnt == c_cnt_w'(CLKS_PER_BIT - 1));
    assign w_last_bit  = (r_idx == c_idx_w'(SIZE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_idx_clr   = 1'b0;
        w_shift_en  = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_clr = 1'b1;
                if (!r_rx_s) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                // Restart the counter at mid-start so later samples land mid-bit
                if (w_mid_start) begin
                    w_cnt_clr = 1'b1;
                    if (r_rx_s) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_idx_clr   = 1'b1;
                        w_state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_shift_en = 1'b1;
                    if (w_last_bit) begin
                        w_state_nxt = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                // Leaving at mid-stop lets a back-to-back start edge be caught
                if (w_bit_end) begin
                    if (r_rx_s) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                w_cnt_clr = 1'b1;
                if (r_rx_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_cnt_clr   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_cnt_clr || w_bit_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_shift <= '0;
        end else if (w_idx_clr) begin
            r_idx   <= '0;
        end else if (w_shift_en) begin
            r_shift[r_idx] <= r_rx_s;
            r_idx          <= r_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data    <= '0;
            r_rx_done <= 1'b0;
        end else begin
            r_rx_done <= w_load;
            if (w_load) begin
                r_data <= r_shift;
            end
        end
    end

    assign bus.rx_done  = r_rx_done;
    assign bus.data_out = r_data;

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_receiver
// Brief    : Randomized self-checking bench for uart_receiver with a frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

    localparam int SIZE = 8;
    localparam int N    = 16;
    localparam int H    = N / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_receiver_if #(.SIZE(SIZE)) bus ();

    uart_receiver #(
        .SIZE         (SIZE),
        .CLKS_PER_BIT (N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int              total       = 0;
    int              bad         = 0;
    int              pulses      = 0;
    int              exp_pulses  = 0;
    logic [SIZE-1:0] last_good   = '0;
    logic [SIZE-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Every strobe must match the oldest outstanding well-framed word
    always @(negedge clk) begin
        if (!rst && bus.rx_done === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) begin
                check("spurious_rx_done", 32'd1, 32'd0);
            end else begin
                check("rx_word", 32'(bus.data_out), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // One bit period; optional one-cycle inverted blip well before mid-bit
    task automatic drive_bit(input logic v, input bit glitch);
        bus.rx = v;
        repeat (2) @(negedge clk);
        if (glitch) begin
            bus.rx = ~v;
            @(negedge clk);
            bus.rx = v;
            repeat (N - 3) @(negedge clk);
        end else begin
            repeat (N - 2) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [SIZE-1:0] d, input logic stop_val, input bit glitchy);
        if (stop_val) begin
            exp_q.push_back(d);
            exp_pulses++;
            last_good = d;
        end
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < SIZE; i++) begin
            drive_bit(d[i], glitchy && ($urandom_range(0, 1) == 1));
        end
        drive_bit(stop_val, glitchy && ($urandom_range(0, 1) == 1));
    endtask

    task automatic settle(input string tag);
        idle(3 * N);
        check({tag, "_pulses"}, 32'(pulses), 32'(exp_pulses));
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_data_out"}, 32'(bus.data_out), 32'(last_good));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [SIZE-1:0] d;
        logic            st;
        int              gap;

        bus.rx = 1'b1;
        rst    = 1'b1;
        repeat (10) @(negedge clk);
        check("reset_rx_done", 32'(bus.rx_done), 32'd0);
        check("reset_data_out", 32'(bus.data_out), 32'd0);
        rst = 1'b0;
        idle(40);
        check("idle_rx_done", 32'(bus.rx_done), 32'd0);
        check("idle_data_out", 32'(bus.data_out), 32'd0);
        check("idle_pulses", 32'(pulses), 32'd0);

        send_frame(8'hA5, 1'b1, 1'b0);
        settle("a5");

        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        settle("b2b");

        bus.rx = 1'b0;
        repeat (N / 4) @(negedge clk);
        settle("short_glitch");

        send_frame(8'h3C, 1'b0, 1'b0);
        idle(2 * N);
        check("frame_err_pulses", 32'(pulses), 32'(exp_pulses));
        send_frame(8'h5A, 1'b1, 1'b0);
        settle("after_frame_err");

        // Abort 0x81 in the middle of data bit 4 with an async reset
        d = 8'h81;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i], 1'b0);
        bus.rx = d[4];
        repeat (H) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midframe_rst_data", 32'(bus.data_out), 32'd0);
        check("midframe_rst_done", 32'(bus.rx_done), 32'd0);
        bus.rx = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        last_good = '0;
        settle("post_reset");
        send_frame(8'h42, 1'b1, 1'b0);
        settle("after_reset");

        for (int n = 0; n < 40; n++) begin
            d   = SIZE'($urandom);
            st  = ($urandom_range(0, 4) != 0);
            send_frame(d, st, 1'b1);
            gap = st ? $urandom_range(0, N) : $urandom_range(4, 2 * N);
            idle(gap);
            if ($urandom_range(0, 5) == 0) begin
                idle(N);
                bus.rx = 1'b0;
                repeat ($urandom_range(1, H - 2)) @(negedge clk);
                idle(2 * N);
            end
            if (n % 10 == 9) settle("random");
        end
        settle("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
